// File: rtl/input_sequencer.sv
// input_sequencer: buffers received bytes and plays them out as a
// mask-modulated, time-multiplexed drive bit for the delay-line reservoir.
module input_sequencer #(
  parameter int          seq_len     = 64,
  parameter int          log_seq_len = 6,
  parameter int          mask_len    = 18,
  parameter logic [31:0] mask        = 32'h0002B5A3,
  parameter int          hold_cycles = 4
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   received,
  input  logic [7:0]             receive_byte,
  input  logic                   load_en,
  input  logic                   clear,
  input  logic                   start,
  output logic                   drive_out,
  output logic                   drive_valid,
  output logic [log_seq_len+2:0] step_idx,
  output logic [log_seq_len:0]   load_count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   done
);
  localparam logic [1:0] IDLE = 2'd0, PLAY = 2'd1, FIN = 2'd2;
  localparam int BW = log_seq_len + 3;
  localparam int CW = log_seq_len + 1;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [4:0]    slot_q, slot_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] load_count_q, load_count_d;
  logic          overflow_q, overflow_d, drive_out_q, drive_out_d;
  logic [7:0]    buf_q [seq_len];
  logic [BW:0]   nbits;
  logic          idle, play, full, wr_en, hold_wrap, slot_wrap, last;
  assign idle      = state_q == IDLE;
  assign play      = state_q == PLAY;
  assign full      = load_count_q == CW'(seq_len);
  assign wr_en     = idle & ~clear & load_en & received & ~full;
  assign nbits     = {load_count_q, 3'b000};
  assign hold_wrap = hold_q == 8'(hold_cycles - 1);
  assign slot_wrap = slot_q == 5'(mask_len - 1);
  assign last      = hold_wrap & slot_wrap & (bit_q == BW'(nbits - 1'b1));
  always_comb begin
    state_d      = state_q;
    bit_d        = bit_q;
    slot_d       = slot_q;
    hold_d       = hold_q;
    load_count_d = load_count_q;
    overflow_d   = overflow_q;
    if (idle) begin
      if (clear) begin
        load_count_d = '0;
        overflow_d   = 1'b0;
      end else if (load_en & received) begin
        overflow_d   = overflow_q | full;
        load_count_d = full ? load_count_q : load_count_q + 1'b1;
      end
      if (start) begin
        state_d = load_count_q == '0 ? FIN : PLAY;
        bit_d   = '0;
        slot_d  = '0;
        hold_d  = '0;
      end
    end else if (play) begin
      hold_d  = hold_wrap ? '0 : hold_q + 1'b1;
      slot_d  = hold_wrap ? (slot_wrap ? '0 : slot_q + 1'b1) : slot_q;
      bit_d   = hold_wrap & slot_wrap ? bit_q + 1'b1 : bit_q;
      state_d = last ? FIN : PLAY;
    end else begin
      state_d = IDLE;
    end
    // Output bit is computed from next-state counters so it is registered in step with them.
    drive_out_d = state_d == PLAY ? buf_q[bit_d[BW-1:3]][bit_d[2:0]] ^ mask[slot_d] : 1'b0;
  end
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_q        <= '0;
      slot_q       <= '0;
      hold_q       <= '0;
      load_count_q <= '0;
      overflow_q   <= 1'b0;
      drive_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      slot_q       <= slot_d;
      hold_q       <= hold_d;
      load_count_q <= load_count_d;
      overflow_q   <= overflow_d;
      drive_out_q  <= drive_out_d;
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) buf_q[load_count_q[log_seq_len-1:0]] <= receive_byte;
  end
  assign drive_out   = drive_out_q;
  assign drive_valid = play;
  assign busy        = play;
  assign done        = state_q == FIN;
  assign step_idx    = bit_q;
  assign load_count  = load_count_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_input_sequencer.sv
// tb_input_sequencer: random and directed stimulus against a queue-based playback model.
module tb_input_sequencer;
  localparam int SEQ = 64, ML = 18, HC = 4;
  localparam logic [31:0] MASK = 32'h0002B5A3;
  logic       clk = 1'b0, reset = 1'b0, received = 1'b0, load_en = 1'b0, clear = 1'b0, start = 1'b0;
  logic [7:0] receive_byte = '0;
  logic       drive_out, drive_valid, overflow, busy, done;
  logic [8:0] step_idx;
  logic [6:0] load_count;
  int         tests = 0, fails = 0;
  logic [7:0] mdl[$];
  bit         movf = 1'b0;
  bit         trace[$], prev[$];
  logic [31:0] mask_v;

  input_sequencer dut (
    .CLOCK_50(clk), .reset(reset), .received(received), .receive_byte(receive_byte),
    .load_en(load_en), .clear(clear), .start(start), .drive_out(drive_out),
    .drive_valid(drive_valid), .step_idx(step_idx), .load_count(load_count),
    .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_bit(input int b);
    logic [7:0] t;
    t = mdl[b >> 3];
    return t[b & 7];
  endfunction

  task automatic load_bytes(input int n, input bit gap);
    load_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      receive_byte = 8'($urandom);
      if (i == 0 && n == 2 && gap) receive_byte = 8'h01;
      if (i == 1 && n == 2 && gap) receive_byte = 8'h80;
      received = 1'b1;
      if (mdl.size() < SEQ) mdl.push_back(receive_byte); else movf = 1'b1;
      @(negedge clk);
      if (gap) begin
        received = 1'b0;
        @(negedge clk);
      end
    end
    received = 1'b0;
    load_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mdl.delete();
    movf = 1'b0;
    @(negedge clk);
  endtask

  task automatic play(input string tag, input bit inject);
    int n, t_len, valid_cnt, errs, done_cnt, done_at, idx, b, s;
    bit e;
    n = mdl.size();
    t_len = 8 * n * ML * HC;
    valid_cnt = 0; errs = 0; done_cnt = 0; done_at = -1;
    trace.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= t_len + 3; c++) begin
      if (drive_valid) valid_cnt++;
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (c <= t_len) begin
        idx = c - 1;
        s = (idx / HC) % ML;
        b = idx / (HC * ML);
        e = in_bit(b) ^ mask_v[s];
        trace.push_back(drive_out);
        if (drive_out !== e || step_idx !== 9'(b) || busy !== 1'b1) errs++;
      end else if (busy !== 1'b0 || drive_valid !== 1'b0) errs++;
      if (inject && c == t_len / 2) begin
        start = 1'b1; clear = 1'b1; load_en = 1'b1; received = 1'b1;
        receive_byte = 8'($urandom);
      end else begin
        start = 1'b0; clear = 1'b0; load_en = 1'b0; received = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_valid_cycles"}, valid_cnt, t_len);
    check({tag, "_trace_errs"}, errs, 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_at"}, done_at, t_len + 1);
    check({tag, "_load_count"}, int'(load_count), n);
    check({tag, "_overflow"}, int'(overflow), int'(movf));
  endtask

  initial begin
    mask_v = MASK;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({drive_out, drive_valid, busy, done, overflow, step_idx, load_count}), 0);
    reset = 1'b1;
    @(negedge clk);
    load_bytes(2, 1'b1);
    check("directed_load_count", int'(load_count), 2);
    play("directed", 1'b0);
    prev = trace;
    play("replay", 1'b0);
    begin
      int d;
      d = 0;
      for (int i = 0; i < prev.size(); i++) if (trace[i] != prev[i]) d++;
      check("replay_diff", d + (trace.size() - prev.size()), 0);
    end
    play("ignored_inputs", 1'b1);
    do_clear();
    load_bytes(65, 1'b0);
    check("ovf_load_count", int'(load_count), 64);
    check("ovf_flag", int'(overflow), 1);
    do_clear();
    check("clear_load_count", int'(load_count), 0);
    check("clear_overflow", int'(overflow), 0);
    play("empty", 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_clear();
      load_bytes(int'($urandom_range(1, 6)), 1'($urandom));
      play($sformatf("rand%0d", k), 1'b0);
    end
    do_clear();
    load_bytes(3, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("midplay_reset_outputs", int'({drive_out, drive_valid, busy, done, overflow, step_idx, load_count}), 0);
    @(negedge clk);
    reset = 1'b1;
    mdl.delete();
    movf = 1'b0;
    @(negedge clk);
    load_bytes(2, 1'b0);
    play("after_reset", 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
